// File: rtl/sr_latch_seq_pkg.sv
// Shared types and constants for the S'R' latch-bank sequencer.
package sr_latch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        VERIFY = 2'd2,
        GAP    = 2'd3
    } seq_state_e;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_q = 1 means B was granted last, so A wins the next tie (reset state).
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Sequencer driving timed active-low set/reset pulses into a NAND S'R' latch bank.
// Optional readback check enabled by defining SR_LATCH_SEQ_VERIFY_EN.
module sr_latch_sequencer
    import sr_latch_seq_pkg::*;
#(
    parameter int N_LATCH      = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter int IDXW         = (N_LATCH > 1) ? $clog2(N_LATCH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a_req,
    input  logic               a_op,
    input  logic [IDXW-1:0]    a_idx,
    output logic               a_ack,
    input  logic               b_req,
    input  logic               b_op,
    input  logic [IDXW-1:0]    b_idx,
    output logic               b_ack,
    output logic [N_LATCH-1:0] s_n,
    output logic [N_LATCH-1:0] r_n,
    input  logic [N_LATCH-1:0] q,
    output logic               busy,
    output logic               err
);

    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNTW    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    // Where the FSM lands after the pulse (or after an illegal-index grant).
    localparam seq_state_e     POST_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;
    localparam logic [CNTW-1:0] PULSE_LOAD = CNTW'(PULSE_CYCLES - 1);
    localparam logic [CNTW-1:0] GAP_LOAD   = CNTW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    seq_state_e         state_q;
    logic [CNTW-1:0]    cnt_q;
    logic [IDXW-1:0]    idx_q;
    logic               exp_q;
    logic [N_LATCH-1:0] s_n_q, r_n_q;
    logic               a_ack_q, b_ack_q, busy_q, err_q;

    logic [1:0]         arb_req, gnt;
    logic               sel_op, idx_ok;
    logic [IDXW-1:0]    sel_idx;
    logic [N_LATCH-1:0] sel_mask;

    // Requests are only visible to the arbiter while idle, so the pointer moves once per grant.
    assign arb_req = (state_q == IDLE) ? {b_req, a_req} : 2'b00;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (arb_req),
        .gnt   (gnt)
    );

    assign sel_op  = gnt[1] ? b_op  : a_op;
    assign sel_idx = gnt[1] ? b_idx : a_idx;
    assign idx_ok  = 32'(sel_idx) < 32'(N_LATCH);

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < N_LATCH; i++) begin
            sel_mask[i] = (32'(sel_idx) == 32'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            exp_q   <= 1'b0;
            s_n_q   <= '1;
            r_n_q   <= '1;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        a_ack_q <= gnt[0];
                        b_ack_q <= gnt[1];
                        idx_q   <= sel_idx;
                        exp_q   <= sel_op;
                        if (idx_ok) begin
                            state_q <= PULSE;
                            busy_q  <= 1'b1;
                            cnt_q   <= PULSE_LOAD;
                            s_n_q   <= (sel_op == OP_SET) ? ~sel_mask : '1;
                            r_n_q   <= (sel_op == OP_SET) ? '1 : ~sel_mask;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= POST_STATE;
                            busy_q  <= (GAP_CYCLES != 0);
                            cnt_q   <= GAP_LOAD;
                        end
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        s_n_q <= '1;
                        r_n_q <= '1;
`ifdef SR_LATCH_SEQ_VERIFY_EN
                        state_q <= VERIFY;
`else
                        state_q <= POST_STATE;
                        busy_q  <= (GAP_CYCLES != 0);
                        cnt_q   <= GAP_LOAD;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef SR_LATCH_SEQ_VERIFY_EN
                VERIFY: begin
                    // Lines have been high for a full cycle, so q has settled.
                    if (q[idx_q] != exp_q) begin
                        err_q <= 1'b1;
                    end
                    state_q <= POST_STATE;
                    busy_q  <= (GAP_CYCLES != 0);
                    cnt_q   <= GAP_LOAD;
                end
`endif
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    s_n_q   <= '1;
                    r_n_q   <= '1;
                end
            endcase
        end
    end

`ifndef SR_LATCH_SEQ_VERIFY_EN
    logic unused_readback;
    assign unused_readback = ^{q, exp_q, idx_q};
`endif

    assign s_n   = s_n_q;
    assign r_n   = r_n_q;
    assign a_ack = a_ack_q;
    assign b_ack = b_ack_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Scoreboard bench for sr_latch_sequencer with a behavioural NAND-latch bank model.
module tb_sr_latch_sequencer;

    localparam int P = 2;
    localparam int G = 1;
`ifdef SR_LATCH_SEQ_VERIFY_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    typedef struct {
        bit who;   // 0 = A, 1 = B
        bit op;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       a_req = 0, a_op = 0, b_req = 0, b_op = 0;
    logic [1:0] a_idx = 0, b_idx = 0;
    logic       a_ack, b_ack, busy, err;
    logic [3:0] s_n, r_n, q;

    logic       a3_req = 0, a3_op = 0;
    logic [1:0] a3_idx = 0;
    logic       a3_ack, b3_ack, busy3, err3;
    logic [2:0] s_n3, r_n3;

    // Latch bank: low s_n sets, low r_n resets, otherwise holds; stuck bits read 0.
    logic [3:0] lq = 4'b0000;
    logic [3:0] stuck = 4'b0000;
    always @(s_n or r_n or stuck) begin
        for (int i = 0; i < 4; i++) begin
            if (!s_n[i]) lq[i] = 1'b1;
            else if (!r_n[i]) lq[i] = 1'b0;
            if (stuck[i]) lq[i] = 1'b0;
        end
    end
    assign q = lq;

    sr_latch_sequencer #(.N_LATCH(4), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_op(a_op), .a_idx(a_idx), .a_ack(a_ack),
        .b_req(b_req), .b_op(b_op), .b_idx(b_idx), .b_ack(b_ack),
        .s_n(s_n), .r_n(r_n), .q(q), .busy(busy), .err(err)
    );

    sr_latch_sequencer #(.N_LATCH(3), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut3 (
        .clk(clk), .reset(reset),
        .a_req(a3_req), .a_op(a3_op), .a_idx(a3_idx), .a_ack(a3_ack),
        .b_req(1'b0), .b_op(1'b0), .b_idx(2'b00), .b_ack(b3_ack),
        .s_n(s_n3), .r_n(r_n3), .q(3'b000), .busy(busy3), .err(err3)
    );

    // Bank-wide invariants: never both lines of a latch low, never more than one line low.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (((~s_n & ~r_n) != 4'b0000) || ($countones({~s_n, ~r_n}) > 1)) begin
                failures++;
                $display("FAIL invariant s_n=%b r_n=%b", s_n, r_n);
            end
        end
    end

    task automatic wait_ack(output bit ga, output bit gb, output bit ok, output int n);
        ga = 0; gb = 0; ok = 0; n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n = i + 1;
            if (a_ack || b_ack) begin
                ga = a_ack; gb = b_ack; ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_timeout busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (s_n !== 4'hF || r_n !== 4'hF || busy !== 1'b0 || err !== 1'b0 ||
                a_ack !== 1'b0 || b_ack !== 1'b0) begin
                failures++;
                $display("FAIL reset_state s_n=%b r_n=%b busy=%b err=%b acks=%b%b required 1111 1111 0 0 00",
                         s_n, r_n, busy, err, a_ack, b_ack);
            end
        end
    endtask

    task automatic test_single();
        exp_t e; bit ga, gb, ok; int n, bc; logic [3:0] es, er;
        @(negedge clk);
        a_op = 1'b1; a_idx = 2'd2; a_req = 1'b1;
        sb.push_back(exp_t'{who: 1'b0, op: 1'b1, idx: 2});
        wait_ack(ga, gb, ok, n);
        a_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || {gb, ga} !== {e.who, ~e.who}) begin
            failures++;
            $display("FAIL single_ack got a=%b b=%b ok=%b required who=%0d", ga, gb, ok, e.who);
        end
        es = e.op ? ~(4'b0001 << e.idx) : 4'hF;
        er = e.op ? 4'hF : ~(4'b0001 << e.idx);
        bc = 0;
        do begin
            bc++;
            checks++;
            if (bc <= P ? (s_n !== es || r_n !== er) : (s_n !== 4'hF || r_n !== 4'hF)) begin
                failures++;
                $display("FAIL single_lines cycle=%0d s_n=%b r_n=%b", bc, s_n, r_n);
            end
            if (bc == 2) begin
                checks++;
                if (a_ack !== 1'b0) begin
                    failures++;
                    $display("FAIL single_ack_width a_ack=%b required 0", a_ack);
                end
            end
            @(negedge clk);
        end while (busy && bc < 20);
        checks++;
        if (bc !== P + V + G) begin
            failures++;
            $display("FAIL single_busy_len got %0d required %0d", bc, P + V + G);
        end
        checks++;
        if (lq[2] !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_result q2=%b err=%b required 1 0", lq[2], err);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; bit ga, gb, ok; int n;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        a_op = 1'b0; a_idx = 2'd1; a_req = 1'b1;
        b_op = 1'b1; b_idx = 2'd1; b_req = 1'b1;
        sb.push_back(exp_t'{who: 1'b0, op: 1'b0, idx: 1});
        sb.push_back(exp_t'{who: 1'b1, op: 1'b1, idx: 1});
        for (int k = 0; k < 2; k++) begin
            wait_ack(ga, gb, ok, n);
            if (ga) a_req = 1'b0;
            if (gb) b_req = 1'b0;
            e = sb.pop_front();
            checks++;
            if (!ok || {gb, ga} !== {e.who, ~e.who}) begin
                failures++;
                $display("FAIL b2b_order grant%0d a=%b b=%b required who=%0d", k, ga, gb, e.who);
            end
            checks++;
            if (e.op ? (s_n !== ~(4'b0001 << e.idx) || r_n !== 4'hF)
                     : (r_n !== ~(4'b0001 << e.idx) || s_n !== 4'hF)) begin
                failures++;
                $display("FAIL b2b_lines grant%0d s_n=%b r_n=%b", k, s_n, r_n);
            end
            if (k == 1) begin
                checks++;
                if (n !== P + V + G + 1) begin
                    failures++;
                    $display("FAIL b2b_interval got %0d required %0d", n, P + V + G + 1);
                end
            end
        end
        wait_idle();
        checks++;
        if (lq[1] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_last_wins q1=%b required 1", lq[1]);
        end
    endtask

    task automatic test_stuck();
        exp_t e; bit ga, gb, ok; int n;
        stuck[3] = 1'b1;
        @(negedge clk);
        b_op = 1'b1; b_idx = 2'd3; b_req = 1'b1;
        sb.push_back(exp_t'{who: 1'b1, op: 1'b1, idx: 3});
        wait_ack(ga, gb, ok, n);
        b_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || {gb, ga} !== {e.who, ~e.who}) begin
            failures++;
            $display("FAIL stuck_ack a=%b b=%b required who=%0d", ga, gb, e.who);
        end
        repeat (P) @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL stuck_err_early err=%b required 0", err);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'(V)) begin
            failures++;
            $display("FAIL stuck_err err=%b required %0d", err, V);
        end
        wait_idle();
        @(negedge clk);
        a_op = 1'b1; a_idx = 2'd0; a_req = 1'b1;
        sb.push_back(exp_t'{who: 1'b0, op: 1'b1, idx: 0});
        wait_ack(ga, gb, ok, n);
        a_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || {gb, ga} !== {e.who, ~e.who}) begin
            failures++;
            $display("FAIL stuck_good_ack a=%b b=%b required who=%0d", ga, gb, e.who);
        end
        wait_idle();
        checks++;
        if (err !== 1'(V) || lq[0] !== 1'b1) begin
            failures++;
            $display("FAIL stuck_sticky err=%b q0=%b required %0d 1", err, lq[0], V);
        end
        stuck[3] = 1'b0;
    endtask

    task automatic test_illegal();
        exp_t e; bit ok; int bc;
        @(negedge clk);
        a3_op = 1'b1; a3_idx = 2'd3; a3_req = 1'b1;
        sb.push_back(exp_t'{who: 1'b0, op: 1'b1, idx: 3});
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a3_ack) begin ok = 1; break; end
        end
        a3_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || b3_ack !== 1'b0 || e.who !== 1'b0) begin
            failures++;
            $display("FAIL illegal_ack ok=%b b3=%b required ack on A", ok, b3_ack);
        end
        checks++;
        if (err3 !== 1'b1) begin
            failures++;
            $display("FAIL illegal_err err=%b required 1", err3);
        end
        bc = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy3) bc++;
            checks++;
            if (s_n3 !== 3'b111 || r_n3 !== 3'b111) begin
                failures++;
                $display("FAIL illegal_lines s_n=%b r_n=%b required 111 111", s_n3, r_n3);
            end
            @(negedge clk);
        end
        checks++;
        if (bc !== G || err3 !== 1'b1) begin
            failures++;
            $display("FAIL illegal_gap busy_cycles=%0d err=%b required %0d 1", bc, err3, G);
        end
    endtask

    task automatic test_reset_mid_pulse();
        exp_t e; bit ga, gb, ok; int n;
        @(negedge clk);
        a_op = 1'b0; a_idx = 2'd2; a_req = 1'b1;
        sb.push_back(exp_t'{who: 1'b0, op: 1'b0, idx: 2});
        wait_ack(ga, gb, ok, n);
        a_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || {gb, ga} !== {e.who, ~e.who} || r_n !== ~(4'b0001 << e.idx)) begin
            failures++;
            $display("FAIL midrst_first a=%b b=%b r_n=%b", ga, gb, r_n);
        end
        @(negedge clk);
        checks++;
        if (r_n !== 4'b1011) begin
            failures++;
            $display("FAIL midrst_second_cycle r_n=%b required 1011", r_n);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (s_n !== 4'hF || r_n !== 4'hF || busy !== 1'b0 || a_ack !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async s_n=%b r_n=%b busy=%b ack=%b err=%b", s_n, r_n, busy, a_ack, err);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        b_op = 1'b1; b_idx = 2'd2; b_req = 1'b1;
        sb.push_back(exp_t'{who: 1'b1, op: 1'b1, idx: 2});
        wait_ack(ga, gb, ok, n);
        b_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || {gb, ga} !== {e.who, ~e.who} || s_n !== ~(4'b0001 << e.idx)) begin
            failures++;
            $display("FAIL midrst_after a=%b b=%b s_n=%b", ga, gb, s_n);
        end
        wait_idle();
        checks++;
        if (lq[2] !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_result q2=%b err=%b required 1 0", lq[2], err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stuck();
        test_illegal();
        test_reset_mid_pulse();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover size=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
